// File: rtl/uart_rx_pkt_buffer_pkg.sv
// Types and constants shared by the UART receive packet buffer and its FIFO.
package uart_rx_pkt_buffer_pkg;
`include "uart_defs.vh"

  localparam int unsigned BYTE_W        = `UART_BYTE_W;
  localparam int unsigned DEPTH_DEFAULT = `UART_DEPTH_DEFAULT;
  localparam int unsigned ENTRY_W       = BYTE_W + 1;

  // FIFO entry: end-of-packet marker in the MSB above the byte
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_defs.vh
// Shared UART constants: byte width and default packet-buffer depth.
`ifndef UART_DEFS_VH
`define UART_DEFS_VH
`define UART_BYTE_W        8
`define UART_DEPTH_DEFAULT 16
`endif

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB wrap pointers; a pop frees space for a same-cycle push.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is never reset; the head is gated by empty so stale words never show
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/uart_rx_pkt_buffer.sv
// Packetizes UART receive bytes: one staged byte waits to learn whether it ends its packet.
module uart_rx_pkt_buffer
  import uart_rx_pkt_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_ready,
  input  logic [BYTE_W-1:0]      rx_data,
  input  logic                   rx_eop,
  output logic                   m_valid,
  output logic [BYTE_W-1:0]      m_data,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   overflow
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              stg_valid;
  logic [BYTE_W-1:0] stg_data;
  rx_entry_t         push_entry;
  rx_entry_t         head;
  logic              push_c;
  logic              pop_c;
  logic              accept_c;
  logic              full;
  logic              empty;
  logic              inc_c;
  logic              dec_c;

  // The staged byte leaves on the next byte (last=0) or on end-of-packet (last=1)
  assign push_c          = stg_valid & (rx_ready | rx_eop);
  assign push_entry.last = rx_eop;
  assign push_entry.data = stg_data;
  assign pop_c           = m_ready & ~empty;
  assign accept_c        = ~full | pop_c;
  assign inc_c           = push_c & push_entry.last & accept_c;
  assign dec_c           = pop_c & head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg_data  <= '0;
    end else if (rx_ready) begin
      stg_valid <= 1'b1;
      stg_data  <= rx_data;
    end else if (rx_eop) begin
      stg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_c && !accept_c) overflow <= 1'b1;
      case ({inc_c, dec_c})
        2'b10:   pkt_count <= pkt_count + CW'(1);
        2'b01:   pkt_count <= pkt_count - CW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (m_ready),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign m_valid = ~empty;
  assign m_data  = head.data;
  assign m_last  = head.last;
endmodule

// File: tb/tb_uart_rx_pkt_buffer.sv
// Directed self-checking bench for uart_rx_pkt_buffer (DEPTH=16).
module tb_uart_rx_pkt_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_eop;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic [4:0] pkt_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_pkt_buffer #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_eop    (rx_eop),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .pkt_count (pkt_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of receive-side stimulus, then inputs return idle
  task automatic pulse(input logic rdy, input logic eop, input logic [7:0] d);
    rx_ready = rdy;
    rx_eop   = eop;
    rx_data  = d;
    tick();
    rx_ready = 1'b0;
    rx_eop   = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] held;
    logic       hold_flag;
    int         idx;
    logic [7:0] bp_bytes [5];

    rst_n    = 1'b0;
    rx_ready = 1'b0;
    rx_eop   = 1'b0;
    rx_data  = 8'h00;
    m_ready  = 1'b0;
    tick();
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_m_last", 32'(m_last), 32'h0);
    check("rst_pkt_count", 32'(pkt_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    tick();

    // Three-byte packet, consumer always ready
    m_ready = 1'b1;
    pulse(1'b1, 1'b0, 8'h41);
    check("p1_staged_not_visible", 32'(m_valid), 32'h0);
    pulse(1'b1, 1'b0, 8'h42);
    check("p1_b0_valid", 32'(m_valid), 32'h1);
    check("p1_b0_data", 32'(m_data), 32'h41);
    check("p1_b0_last", 32'(m_last), 32'h0);
    pulse(1'b1, 1'b0, 8'h43);
    check("p1_b1_data", 32'(m_data), 32'h42);
    check("p1_b1_last", 32'(m_last), 32'h0);
    pulse(1'b0, 1'b1, 8'h00);
    check("p1_b2_data", 32'(m_data), 32'h43);
    check("p1_b2_last", 32'(m_last), 32'h1);
    check("p1_pkt_peak", 32'(pkt_count), 32'h1);
    tick();
    check("p1_drained_valid", 32'(m_valid), 32'h0);
    check("p1_drained_pkt", 32'(pkt_count), 32'h0);

    // End-of-packet with nothing staged is ignored
    pulse(1'b0, 1'b1, 8'h00);
    check("eop_empty_valid", 32'(m_valid), 32'h0);
    check("eop_empty_pkt", 32'(pkt_count), 32'h0);
    tick();
    check("eop_empty_valid2", 32'(m_valid), 32'h0);

    // Byte coincident with end-of-packet: old byte closes packet, new byte stays staged
    pulse(1'b1, 1'b0, 8'h10);
    check("coin_staged", 32'(m_valid), 32'h0);
    pulse(1'b1, 1'b1, 8'h55);
    check("coin_valid", 32'(m_valid), 32'h1);
    check("coin_data", 32'(m_data), 32'h10);
    check("coin_last", 32'(m_last), 32'h1);
    check("coin_pkt", 32'(pkt_count), 32'h1);
    tick();
    check("coin_55_held", 32'(m_valid), 32'h0);
    check("coin_pkt_after", 32'(pkt_count), 32'h0);
    pulse(1'b0, 1'b1, 8'h00);
    check("coin_55_data", 32'(m_data), 32'h55);
    check("coin_55_last", 32'(m_last), 32'h1);
    tick();
    check("coin_drained", 32'(m_valid), 32'h0);

    // Full FIFO with a simultaneous pop still accepts the push
    m_ready = 1'b0;
    for (int i = 1; i <= 17; i++) pulse(1'b1, 1'b0, 8'(i));
    check("full_no_ovf", 32'(overflow), 32'h0);
    check("full_head", 32'(m_data), 32'h01);
    m_ready = 1'b1;
    pulse(1'b1, 1'b0, 8'd18);
    check("full_pushpop_ovf", 32'(overflow), 32'h0);
    check("full_pushpop_head", 32'(m_data), 32'h02);
    m_ready = 1'b0;
    do_reset();

    // Overflow: 18 bytes then eop into a stalled 16-entry FIFO
    for (int i = 1; i <= 17; i++) pulse(1'b1, 1'b0, 8'(i));
    check("ovf_before", 32'(overflow), 32'h0);
    pulse(1'b1, 1'b0, 8'd18);
    check("ovf_set", 32'(overflow), 32'h1);
    pulse(1'b0, 1'b1, 8'h00);
    check("ovf_pkt_dropped", 32'(pkt_count), 32'h0);
    check("ovf_valid", 32'(m_valid), 32'h1);
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("ovf_drain_data%0d", i), 32'(m_data), 32'(i));
      check($sformatf("ovf_drain_last%0d", i), 32'(m_last), 32'h0);
      tick();
    end
    check("ovf_drained", 32'(m_valid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    check("ovf_pkt_end", 32'(pkt_count), 32'h0);
    do_reset();
    check("ovf_reset_clear", 32'(overflow), 32'h0);

    // Backpressure: m_ready toggles each cycle during a 5-byte packet
    bp_bytes[0] = 8'hA0; bp_bytes[1] = 8'hA1; bp_bytes[2] = 8'hA2;
    bp_bytes[3] = 8'hA3; bp_bytes[4] = 8'hA4;
    idx     = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      rx_ready  = (c < 5);
      rx_eop    = (c == 5);
      rx_data   = (c < 5) ? bp_bytes[c] : 8'h00;
      hold_flag = 1'b0;
      held      = m_data;
      if (m_valid && m_ready) begin
        check($sformatf("bp_data%0d", idx), 32'(m_data), 32'(bp_bytes[idx % 5]));
        check($sformatf("bp_last%0d", idx), 32'(m_last), 32'(idx == 4));
        idx++;
      end else if (m_valid) begin
        hold_flag = 1'b1;
      end
      tick();
      if (hold_flag) check($sformatf("bp_stable_c%0d", c), 32'(m_data), 32'(held));
      m_ready = ~m_ready;
    end
    rx_ready = 1'b0;
    rx_eop   = 1'b0;
    check("bp_count", 32'(idx), 32'd5);
    check("bp_empty", 32'(m_valid), 32'h0);
    check("bp_pkt", 32'(pkt_count), 32'h0);

    // Reset mid-packet discards staging and FIFO contents at once
    m_ready = 1'b0;
    pulse(1'b1, 1'b0, 8'hB1);
    pulse(1'b1, 1'b0, 8'hB2);
    pulse(1'b1, 1'b0, 8'hB3);
    pulse(1'b1, 1'b0, 8'hB4);
    check("mid_valid_before", 32'(m_valid), 32'h1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(m_valid), 32'h0);
    check("mid_rst_pkt", 32'(pkt_count), 32'h0);
    check("mid_rst_data", 32'(m_data), 32'h0);
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    check("mid_rel_valid", 32'(m_valid), 32'h0);
    pulse(1'b1, 1'b0, 8'hC1);
    check("mid_no_stale_push", 32'(m_valid), 32'h0);
    pulse(1'b1, 1'b0, 8'hC2);
    check("mid_c1_data", 32'(m_data), 32'hC1);
    check("mid_c1_last", 32'(m_last), 32'h0);
    pulse(1'b0, 1'b1, 8'h00);
    check("mid_c2_data", 32'(m_data), 32'hC2);
    check("mid_c2_last", 32'(m_last), 32'h1);
    check("mid_c2_pkt", 32'(pkt_count), 32'h1);
    tick();
    check("mid_done_valid", 32'(m_valid), 32'h0);
    check("mid_done_pkt", 32'(pkt_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
